// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer.
// Accepts one request at a time from IDLE: a synchronous exception, an
// interrupt when i_mie=1, or an MRET, in that priority order. An exception
// or interrupt writes mepc/mcause in SAVE, computes the handler address from
// mtvec in VECTOR and then presents it in REDIRECT. An MRET goes directly to
// REDIRECT with the aligned mepc.
//
// Ports
//   clk, arst                 clock, asynchronous active-high reset
//   i_exc_valid/cause/pc      exception request (held until o_ack)
//   i_irq_valid/cause/pc      interrupt request (held until o_ack)
//   i_mie                     global interrupt enable
//   i_mret                    MRET request (held until o_ack)
//   i_mtvec_data, i_mepc_data current CSR values
//   i_redirect_ready          fetch accepts the redirect
//   o_mepc_we/data            mepc write port (SAVE only)
//   o_mcause_we/data          mcause write port (SAVE only)
//   o_ack                     one-cycle acceptance pulse
//   o_redirect_valid/pc       redirect handshake (REDIRECT only)
//   o_busy                    high whenever the FSM is not IDLE
//
// state    | meaning
// IDLE     | arbitrate and accept a request
// SAVE     | write mepc and mcause
// VECTOR   | compute handler target from mtvec
// REDIRECT | present target until fetch accepts it
module trap_ctrl #(
  parameter int REG_DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic                      i_exc_valid,
  input  logic [3:0]                i_exc_cause,
  input  logic [REG_DATA_WIDTH-1:0] i_exc_pc,
  input  logic                      i_irq_valid,
  input  logic [3:0]                i_irq_cause,
  input  logic [REG_DATA_WIDTH-1:0] i_irq_pc,
  input  logic                      i_mie,
  input  logic                      i_mret,
  input  logic [REG_DATA_WIDTH-1:0] i_mtvec_data,
  input  logic [REG_DATA_WIDTH-1:0] i_mepc_data,
  input  logic                      i_redirect_ready,
  output logic                      o_mepc_we,
  output logic [REG_DATA_WIDTH-1:0] o_mepc_data,
  output logic                      o_mcause_we,
  output logic [REG_DATA_WIDTH-1:0] o_mcause_data,
  output logic                      o_ack,
  output logic                      o_redirect_valid,
  output logic [REG_DATA_WIDTH-1:0] o_redirect_pc,
  output logic                      o_busy
);

  localparam int W = REG_DATA_WIDTH;
  localparam logic [W-1:0] ALIGN_MASK = {{(W-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {IDLE, SAVE, VECTOR, REDIRECT} state_t;

  state_t         state_q, state_d;
  logic           is_irq_q, is_irq_d;
  logic [3:0]     cause_q, cause_d;
  logic [W-1:0]   pc_q, pc_d;
  logic [W-1:0]   target_q, target_d;
  logic           ack;
  logic [W-1:0]   vec_offset;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q  <= IDLE;
      is_irq_q <= 1'b0;
      cause_q  <= '0;
      pc_q     <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      is_irq_q <= is_irq_d;
      cause_q  <= cause_d;
      pc_q     <= pc_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    is_irq_d   = is_irq_q;
    cause_d    = cause_q;
    pc_d       = pc_q;
    target_d   = target_q;
    ack        = 1'b0;
    vec_offset = '0;
    case (state_q)
      IDLE: begin
        if (i_exc_valid) begin
          ack      = 1'b1;
          is_irq_d = 1'b0;
          cause_d  = i_exc_cause;
          pc_d     = i_exc_pc;
          state_d  = SAVE;
        end else if (i_irq_valid && i_mie) begin
          ack      = 1'b1;
          is_irq_d = 1'b1;
          cause_d  = i_irq_cause;
          pc_d     = i_irq_pc;
          state_d  = SAVE;
        end else if (i_mret) begin
          ack      = 1'b1;
          is_irq_d = 1'b0;
          target_d = i_mepc_data & ALIGN_MASK;
          state_d  = REDIRECT;
        end
      end
      SAVE: state_d = VECTOR;
      VECTOR: begin
        // Vectored mode only offsets interrupts; exceptions always use base.
        if (is_irq_q && (i_mtvec_data[1:0] == 2'b01)) begin
          vec_offset[5:0] = {cause_q, 2'b00};
        end
        target_d = (i_mtvec_data & ALIGN_MASK) + vec_offset;
        state_d  = REDIRECT;
      end
      REDIRECT: begin
        if (i_redirect_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ack is combinational from held inputs, so it is masked during reset.
  assign o_ack            = ack & ~arst;
  assign o_mepc_we        = (state_q == SAVE);
  assign o_mcause_we      = (state_q == SAVE);
  assign o_mepc_data      = (state_q == SAVE) ? (pc_q & ALIGN_MASK) : '0;
  assign o_mcause_data    = (state_q == SAVE) ? {is_irq_q, {(W-5){1'b0}}, cause_q} : '0;
  assign o_redirect_valid = (state_q == REDIRECT);
  assign o_redirect_pc    = (state_q == REDIRECT) ? target_q : '0;
  assign o_busy           = (state_q != IDLE);

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;
  localparam int W = 64;
  localparam int K_NONE = 0, K_EXC = 1, K_IRQ = 2, K_MRET = 3;

  logic         clk = 1'b0;
  logic         arst;
  logic         i_exc_valid, i_irq_valid, i_mie, i_mret, i_redirect_ready;
  logic [3:0]   i_exc_cause, i_irq_cause;
  logic [W-1:0] i_exc_pc, i_irq_pc, i_mtvec_data, i_mepc_data;
  logic         o_mepc_we, o_mcause_we, o_ack, o_redirect_valid, o_busy;
  logic [W-1:0] o_mepc_data, o_mcause_data, o_redirect_pc;

  int n_cmp = 0;
  int n_fail = 0;

  trap_ctrl #(.REG_DATA_WIDTH(W)) dut (
    .clk(clk), .arst(arst),
    .i_exc_valid(i_exc_valid), .i_exc_cause(i_exc_cause), .i_exc_pc(i_exc_pc),
    .i_irq_valid(i_irq_valid), .i_irq_cause(i_irq_cause), .i_irq_pc(i_irq_pc),
    .i_mie(i_mie), .i_mret(i_mret),
    .i_mtvec_data(i_mtvec_data), .i_mepc_data(i_mepc_data),
    .i_redirect_ready(i_redirect_ready),
    .o_mepc_we(o_mepc_we), .o_mepc_data(o_mepc_data),
    .o_mcause_we(o_mcause_we), .o_mcause_data(o_mcause_data),
    .o_ack(o_ack), .o_redirect_valid(o_redirect_valid),
    .o_redirect_pc(o_redirect_pc), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         exc_v;
    logic [3:0]   exc_c;
    logic [W-1:0] exc_pc;
    logic         irq_v;
    logic [3:0]   irq_c;
    logic [W-1:0] irq_pc;
    logic         mie;
    logic         mret;
    logic [W-1:0] mtvec;
    logic [W-1:0] mepc;
    int           kind;
    logic [W-1:0] e_mepc;
    logic [W-1:0] e_mcause;
    logic [W-1:0] e_target;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    i_exc_valid  = v.exc_v;  i_exc_cause = v.exc_c; i_exc_pc = v.exc_pc;
    i_irq_valid  = v.irq_v;  i_irq_cause = v.irq_c; i_irq_pc = v.irq_pc;
    i_mie        = v.mie;    i_mret      = v.mret;
    i_mtvec_data = v.mtvec;  i_mepc_data = v.mepc;
  endtask

  task automatic clear_reqs();
    i_exc_valid = 1'b0; i_irq_valid = 1'b0; i_mret = 1'b0;
  endtask

  // Reference: trap rules expressed as plain arithmetic on the request.
  function automatic void model(input vec_t v, output int kind,
                                output logic [W-1:0] m, output logic [W-1:0] c,
                                output logic [W-1:0] t);
    logic [W-1:0] pc, cause;
    kind = K_NONE; pc = 0; cause = 0;
    if (v.exc_v) begin kind = K_EXC; pc = v.exc_pc; cause = W'(v.exc_c); end
    else if (v.irq_v && v.mie) begin kind = K_IRQ; pc = v.irq_pc; cause = W'(v.irq_c); end
    else if (v.mret) kind = K_MRET;
    m = pc - (pc % 4);
    c = cause + ((kind == K_IRQ) ? 64'h8000_0000_0000_0000 : 64'h0);
    if (kind == K_MRET) t = v.mepc - (v.mepc % 4);
    else t = (v.mtvec - (v.mtvec % 4)) + ((kind == K_IRQ && (v.mtvec % 4) == 1) ? cause * 4 : 64'h0);
  endfunction

  // Called at a negedge with the FSM in IDLE and inputs already driven.
  task automatic run_seq(input int kind, input logic [W-1:0] e_mepc,
                         input logic [W-1:0] e_mcause, input logic [W-1:0] e_target,
                         input int stall, input string tag);
    #1;
    if (kind == K_NONE) begin
      chk({tag, ".noack"}, W'(o_ack), 0);
      @(posedge clk);
      @(negedge clk);
      chk({tag, ".idle_busy"}, W'(o_busy), 0);
      return;
    end
    chk({tag, ".ack"}, W'(o_ack), 1);
    @(posedge clk);
    #1;
    case (kind)
      K_EXC:   i_exc_valid = 1'b0;
      K_IRQ:   i_irq_valid = 1'b0;
      default: i_mret = 1'b0;
    endcase
    if (kind != K_MRET) begin
      @(negedge clk);
      chk({tag, ".save_mepc_we"}, W'(o_mepc_we), 1);
      chk({tag, ".save_mcause_we"}, W'(o_mcause_we), 1);
      chk({tag, ".save_mepc"}, o_mepc_data, e_mepc);
      chk({tag, ".save_mcause"}, o_mcause_data, e_mcause);
      chk({tag, ".save_rv"}, W'(o_redirect_valid), 0);
      @(negedge clk);
      chk({tag, ".vec_we"}, W'({o_mepc_we, o_mcause_we}), 0);
      chk({tag, ".vec_rv"}, W'(o_redirect_valid), 0);
      chk({tag, ".vec_busy"}, W'(o_busy), 1);
    end
    @(negedge clk);
    chk({tag, ".redir_valid"}, W'(o_redirect_valid), 1);
    chk({tag, ".redir_pc"}, o_redirect_pc, e_target);
    chk({tag, ".redir_we"}, W'({o_mepc_we, o_mcause_we}), 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, ".stall_valid"}, W'(o_redirect_valid), 1);
      chk({tag, ".stall_pc"}, o_redirect_pc, e_target);
    end
    i_redirect_ready = 1'b1;
    @(negedge clk);
    i_redirect_ready = 1'b0;
    chk({tag, ".done_busy"}, W'(o_busy), 0);
    chk({tag, ".done_rv"}, W'(o_redirect_valid), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int kind;
    logic [W-1:0] em, ec, et;

    tbl[0] = '{1'b1, 4'd2, 64'h1003, 1'b0, 4'd0, 64'h0, 1'b0, 1'b0, 64'h8000_0001, 64'h0,
               K_EXC, 64'h1000, 64'h2, 64'h8000_0000};
    tbl[1] = '{1'b0, 4'd0, 64'h0, 1'b1, 4'd7, 64'h2000, 1'b1, 1'b0, 64'h8000_0001, 64'h0,
               K_IRQ, 64'h2000, 64'h8000_0000_0000_0007, 64'h8000_001C};
    tbl[2] = '{1'b0, 4'd0, 64'h0, 1'b1, 4'd5, 64'h3006, 1'b1, 1'b0, 64'h4000_0000, 64'h0,
               K_IRQ, 64'h3004, 64'h8000_0000_0000_0005, 64'h4000_0000};
    tbl[3] = '{1'b0, 4'd0, 64'h0, 1'b0, 4'd0, 64'h0, 1'b0, 1'b1, 64'h0, 64'h1237,
               K_MRET, 64'h0, 64'h0, 64'h1234};
    tbl[4] = '{1'b0, 4'd0, 64'h0, 1'b1, 4'd6, 64'h50, 1'b0, 1'b1, 64'h0, 64'hABCD,
               K_MRET, 64'h0, 64'h0, 64'hABCC};
    tbl[5] = '{1'b0, 4'd0, 64'h0, 1'b1, 4'd15, 64'h10, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF1, 64'h0,
               K_IRQ, 64'h10, 64'h8000_0000_0000_000F, 64'h2C};
    tbl[6] = '{1'b1, 4'd11, 64'hFFFF, 1'b0, 4'd0, 64'h0, 1'b1, 1'b0, 64'h101, 64'h0,
               K_EXC, 64'hFFFC, 64'hB, 64'h100};
    tbl[7] = '{1'b0, 4'd0, 64'h0, 1'b1, 4'd3, 64'h77, 1'b1, 1'b0, 64'h202, 64'h0,
               K_IRQ, 64'h74, 64'h8000_0000_0000_0003, 64'h200};
    tbl[8] = '{1'b0, 4'd0, 64'h0, 1'b1, 4'd4, 64'h88, 1'b0, 1'b0, 64'h0, 64'h0,
               K_NONE, 64'h0, 64'h0, 64'h0};

    arst = 1'b1;
    i_redirect_ready = 1'b0;
    clear_reqs();
    i_exc_cause = 0; i_irq_cause = 0; i_exc_pc = 0; i_irq_pc = 0;
    i_mie = 0; i_mtvec_data = 0; i_mepc_data = 0;
    #1;
    chk("rst.busy", W'(o_busy), 0);
    chk("rst.ack", W'(o_ack), 0);
    chk("rst.we", W'({o_mepc_we, o_mcause_we}), 0);
    chk("rst.rv", W'(o_redirect_valid), 0);
    chk("rst.rpc", o_redirect_pc, 0);
    repeat (2) @(negedge clk);
    arst = 1'b0;

    foreach (tbl[i]) begin
      apply(tbl[i]);
      run_seq(tbl[i].kind, tbl[i].e_mepc, tbl[i].e_mcause, tbl[i].e_target, i % 3,
              $sformatf("tbl%0d", i));
      clear_reqs();
    end

    // All three requests together: served in priority order.
    i_exc_valid = 1'b1; i_exc_cause = 4'd1; i_exc_pc = 64'h104;
    i_irq_valid = 1'b1; i_irq_cause = 4'd3; i_irq_pc = 64'h208;
    i_mie = 1'b1; i_mret = 1'b1; i_mtvec_data = 64'h1001; i_mepc_data = 64'h30B;
    run_seq(K_EXC, 64'h104, 64'h1, 64'h1000, 0, "prio_exc");
    run_seq(K_IRQ, 64'h208, 64'h8000_0000_0000_0003, 64'h100C, 0, "prio_irq");
    run_seq(K_MRET, 64'h0, 64'h0, 64'h308, 0, "prio_mret");
    clear_reqs();

    // Masked interrupt stays pending, then taken once enabled; long stall.
    i_irq_valid = 1'b1; i_irq_cause = 4'd9; i_irq_pc = 64'h40;
    i_mie = 1'b0; i_mtvec_data = 64'h11;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("masked.ack", W'(o_ack), 0);
      chk("masked.busy", W'(o_busy), 0);
      @(negedge clk);
    end
    i_mie = 1'b1;
    run_seq(K_IRQ, 64'h40, 64'h8000_0000_0000_0009, 64'h34, 5, "unmask");
    clear_reqs();

    // Reset during VECTOR aborts; the still-held exception is taken again.
    i_exc_valid = 1'b1; i_exc_cause = 4'd4; i_exc_pc = 64'h502; i_mtvec_data = 64'h901;
    #1;
    chk("rstmid.ack", W'(o_ack), 1);
    @(negedge clk);
    chk("rstmid.save_we", W'(o_mepc_we), 1);
    @(negedge clk);
    chk("rstmid.vec_busy", W'(o_busy), 1);
    arst = 1'b1;
    #1;
    chk("rstmid.busy", W'(o_busy), 0);
    chk("rstmid.ack0", W'(o_ack), 0);
    chk("rstmid.we", W'({o_mepc_we, o_mcause_we}), 0);
    chk("rstmid.data", o_mepc_data | o_mcause_data, 0);
    chk("rstmid.rv", W'(o_redirect_valid), 0);
    chk("rstmid.rpc", o_redirect_pc, 0);
    repeat (3) begin
      @(negedge clk);
      chk("rstmid.hold_rv", W'(o_redirect_valid), 0);
      chk("rstmid.hold_busy", W'(o_busy), 0);
    end
    arst = 1'b0;
    run_seq(K_EXC, 64'h500, 64'h4, 64'h900, 0, "rerun");
    clear_reqs();

    // Randomized requests against the reference model.
    for (int n = 0; n < 60; n++) begin
      v.exc_v  = ($urandom_range(0, 3) == 0);
      v.exc_c  = 4'($urandom);
      v.exc_pc = {$urandom, $urandom};
      v.irq_v  = ($urandom_range(0, 1) == 1);
      v.irq_c  = 4'($urandom);
      v.irq_pc = {$urandom, $urandom};
      v.mie    = ($urandom_range(0, 3) != 0);
      v.mret   = ($urandom_range(0, 2) == 0);
      v.mtvec  = {$urandom, $urandom};
      v.mepc   = {$urandom, $urandom};
      v.kind = 0; v.e_mepc = 0; v.e_mcause = 0; v.e_target = 0;
      model(v, kind, em, ec, et);
      apply(v);
      run_seq(kind, em, ec, et, $urandom_range(0, 2), $sformatf("rnd%0d", n));
      clear_reqs();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 The block SHALL have parameter REG_DATA_WIDTH, default 64, giving the CSR and PC width (W).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port arst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port i_exc_valid, input, 1 bit: synchronous exception request, held by requester until acked.
REQ-005 The block SHALL have port i_exc_cause, input, 4 bits: exception code.
REQ-006 The block SHALL have port i_exc_pc, input, W bits: PC of the faulting instruction.
REQ-007 The block SHALL have port i_irq_valid, input, 1 bit: interrupt request, held until acked.
REQ-008 The block SHALL have port i_irq_cause, input, 4 bits: interrupt code.
REQ-009 The block SHALL have port i_irq_pc, input, W bits: resume PC for the interrupt.
REQ-010 The block SHALL have port i_mie, input, 1 bit: global interrupt enable.
REQ-011 The block SHALL have port i_mret, input, 1 bit: MRET request, held until acked.
REQ-012 The block SHALL have port i_mtvec_data, input, W bits: current mtvec CSR value.
REQ-013 The block SHALL have port i_mepc_data, input, W bits: current mepc CSR value.
REQ-014 The block SHALL have port i_redirect_ready, input, 1 bit: fetch accepts redirect.
REQ-015 The block SHALL have ports o_mepc_we (1 bit), o_mepc_data (W), o_mcause_we (1 bit), o_mcause_data (W), all outputs: CSR write controls.
REQ-016 The block SHALL have port o_ack, output, 1 bit: one-cycle pulse when a request is accepted.
REQ-017 The block SHALL have ports o_redirect_valid (1 bit) and o_redirect_pc (W), outputs: PC redirect handshake.
REQ-018 The block SHALL have port o_busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, SAVE, VECTOR, REDIRECT.
REQ-020 A request SHALL be accepted only in IDLE; priority is exception > interrupt (only if i_mie=1) > MRET; lower-priority simultaneous requests SHALL NOT be acked.
REQ-021 On acceptance, o_ack SHALL pulse for that cycle and the type, cause and PC SHALL be latched internally.
REQ-022 On an exception or interrupt, IDLE SHALL go to SAVE; on MRET, IDLE SHALL go to REDIRECT with target {i_mepc_data[W-1:2],2'b00} latched at acceptance.
REQ-023 SAVE SHALL last exactly one cycle and assert o_mepc_we and o_mcause_we together, then go to VECTOR.
REQ-024 In SAVE, o_mepc_data SHALL be the latched PC with bits [1:0] forced to 0.
REQ-025 In SAVE, o_mcause_data SHALL be {1'b0, zeros, cause} for an exception and {1'b1, zeros, cause} for an interrupt, with the cause in bits [3:0].
REQ-026 VECTOR SHALL last one cycle and latch the target: base = {i_mtvec_data[W-1:2],2'b00}; if i_mtvec_data[1:0]==1 and the request is an interrupt, target = base + 4*cause; else (mode 0/2/3, or exception) target = base. Addition SHALL be W-bit and wrap modulo 2^W.
REQ-027 In REDIRECT, o_redirect_valid SHALL be 1 and o_redirect_pc stable until the cycle i_redirect_ready=1, after which the FSM SHALL return to IDLE.
REQ-028 New requests SHALL NOT be accepted in the REDIRECT→IDLE handoff cycle; the earliest next acceptance is the cycle after the FSM is in IDLE.
REQ-029 Write enables SHALL be 0 outside SAVE; o_redirect_valid SHALL be 0 outside REDIRECT.
REQ-030 Exception/interrupt latency SHALL be: acceptance cycle N, SAVE N+1, VECTOR N+2, o_redirect_valid first high at N+3.

Reset
REQ-031 While arst=1, the state SHALL be IDLE and o_ack, o_mepc_we, o_mcause_we, o_redirect_valid and o_busy SHALL be 0; o_mepc_data, o_mcause_data and o_redirect_pc SHALL be 0.
REQ-032 Reset asserted mid-sequence SHALL abort it immediately with no CSR write completing after assertion; after deassertion, held requests SHALL be re-arbitrated from IDLE.

Verification
REQ-033 Exception with cause=2, pc=0x1003, mtvec=0x8000_0001 -> ack at N; at N+1 mepc_we=1, mepc=0x1000, mcause=0x2; redirect_pc=0x8000_0000 at N+3.
REQ-034 Interrupt with cause=7, mie=1, mtvec=0x8000_0001 -> mcause=0x8000_0000_0000_0007; redirect_pc=0x8000_001C.
REQ-035 Exception, interrupt and MRET asserted together -> only the exception is acked; after return to IDLE the interrupt is acked next; MRET is acked last, with redirect_pc = mepc & ~3.
REQ-036 Interrupt with mie=0 -> no ack and o_busy stays 0 for 10 cycles; raising mie -> ack next cycle.
REQ-037 i_redirect_ready held 0 for 5 cycles in REDIRECT -> o_redirect_valid/o_redirect_pc stable all 5 cycles; ready=1 -> IDLE next cycle.
REQ-038 arst pulsed in VECTOR -> all outputs 0 asynchronously, no redirect issued; after release, the held exception is re-acked and the full sequence is rerun.
